// File: rtl/step_ctrl.sv
// Pushbutton sequencer for the 4-digit decimal step counter: synchronizes the
// buttons, selects the active digit and issues single and hold-to-repeat enable pulses.
module step_ctrl #(
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned HOLD_DELAY    = 500,
    parameter int unsigned REPEAT_PERIOD = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_sel,
    output logic       direction,
    output logic       enable,
    output logic [9:0] step,
    output logic [1:0] digit_idx
);

    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TICK_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] HOLD_LAST = TICK_W'(HOLD_DELAY - 1);
    localparam logic [TICK_W-1:0] REP_LAST  = TICK_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [2:0]        sync_m, sync_s;
    logic              sel_q;
    logic [PRE_W-1:0]  presc, presc_d;
    logic [TICK_W-1:0] tick, tick_d, tick_last;
    logic              dir_d, enable_d, abort;
    logic [1:0]        digit_d;
    logic              up_s, dn_s, sel_s, sel_edge;

    function automatic logic [9:0] step_of(input logic [1:0] d);
        case (d)
            2'd0:    return 10'd1;
            2'd1:    return 10'd10;
            2'd2:    return 10'd100;
            default: return 10'd1000;
        endcase
    endfunction

    assign up_s     = sync_s[0];
    assign dn_s     = sync_s[1];
    assign sel_s    = sync_s[2];
    assign sel_edge = sel_s & ~sel_q;

    // Two-flop synchronizers plus the select edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_m <= '0;
            sync_s <= '0;
            sel_q  <= 1'b0;
        end else begin
            sync_m <= {btn_sel, btn_dn, btn_up};
            sync_s <= sync_m;
            sel_q  <= sync_s[2];
        end
    end

    // State register together with the registered outputs and timing counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            direction <= 1'b0;
            enable    <= 1'b0;
            digit_idx <= 2'd0;
            step      <= 10'd1;
            presc     <= '0;
            tick      <= '0;
        end else begin
            state     <= state_d;
            direction <= dir_d;
            enable    <= enable_d;
            digit_idx <= digit_d;
            step      <= step_of(digit_d);
            presc     <= presc_d;
            tick      <= tick_d;
        end
    end

    // Next-state logic; a press is dropped if the held button releases or both are down.
    always_comb begin
        state_d   = state;
        dir_d     = direction;
        enable_d  = 1'b0;
        digit_d   = digit_idx;
        presc_d   = presc;
        tick_d    = tick;
        tick_last = (state == HOLD) ? HOLD_LAST : REP_LAST;
        abort     = direction ? (~up_s | dn_s) : (~dn_s | up_s);

        unique case (state)
            IDLE: begin
                if (sel_edge) begin
                    digit_d = digit_idx + 2'd1;
                end else if (up_s ^ dn_s) begin
                    dir_d    = up_s;
                    enable_d = 1'b1;
                    presc_d  = '0;
                    tick_d   = '0;
                    state_d  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (abort) begin
                    presc_d = '0;
                    tick_d  = '0;
                    state_d = IDLE;
                end else if (presc == PRE_LAST) begin
                    presc_d = '0;
                    if (tick == tick_last) begin
                        enable_d = 1'b1;
                        tick_d   = '0;
                        state_d  = REPEAT;
                    end else begin
                        tick_d = tick + TICK_W'(1);
                    end
                end else begin
                    presc_d = presc + PRE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: a cycle-level behavioural model predicts each
// enable pulse and the digit/step/direction state; a monitor checks the DUT against it.
module tb_step_ctrl;

    localparam int TD = 4;
    localparam int HD = 3;
    localparam int RP = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_up, btn_dn, btn_sel;
    logic       direction, enable;
    logic [9:0] step;
    logic [1:0] digit_idx;

    step_ctrl #(
        .TICK_DIV     (TD),
        .HOLD_DELAY   (HD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .btn_sel  (btn_sel),
        .direction(direction),
        .enable   (enable),
        .step     (step),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       dir;
        logic [9:0] stp;
        logic [1:0] dig;
    } pulse_t;

    pulse_t q[$];
    int     cyc        = 0;
    int     vectors    = 0;
    int     miscompares = 0;

    // Model state: raw-input history, press mode (0 idle, 1 first wait, 2 repeating).
    logic [2:0] hu = '0, hd = '0, hs = '0;
    int         mode    = 0;
    logic       m_dir   = 1'b0;
    int         m_digit = 0;
    int         elapsed = 0;

    function automatic logic [9:0] step_for(input int d);
        int s = 1;
        for (int i = 0; i < d; i++) s = s * 10;
        return 10'(s);
    endfunction

    // Reference model: the FSM sees each raw level two edges late.
    always @(posedge clk) begin : model
        logic u, d, s, sp;
        cyc = cyc + 1;
        if (!reset_n) begin
            hu = '0; hd = '0; hs = '0;
            mode = 0; m_dir = 1'b0; m_digit = 0; elapsed = 0;
            q.delete();
        end else begin
            u  = hu[1];
            d  = hd[1];
            s  = hs[1];
            sp = hs[2];
            if (mode == 0) begin
                if (s && !sp) begin
                    m_digit = (m_digit + 1) % 4;
                end else if (u != d) begin
                    m_dir   = u;
                    mode    = 1;
                    elapsed = 0;
                    q.push_back('{cyc, m_dir, step_for(m_digit), 2'(m_digit)});
                end
            end else begin
                if (m_dir ? (!u || d) : (!d || u)) begin
                    mode = 0;
                end else begin
                    elapsed = elapsed + 1;
                    if (elapsed == ((mode == 1) ? HD * TD : RP * TD)) begin
                        q.push_back('{cyc, m_dir, step_for(m_digit), 2'(m_digit)});
                        elapsed = 0;
                        mode    = 2;
                    end
                end
            end
            hu = {hu[1:0], btn_up};
            hd = {hd[1:0], btn_dn};
            hs = {hs[1:0], btn_sel};
        end
    end

    // Monitor: pops the expected pulse whenever enable shows, flags missed pulses.
    always @(negedge clk) begin : monitor
        pulse_t p;
        if (reset_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_pulse cyc=%0d expected at cyc=%0d got enable=0 want enable=1",
                         cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (enable) begin
                vectors++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc=%0d got enable=1 want enable=0", cyc);
                end else begin
                    p = q.pop_front();
                    if ({direction, step, digit_idx} !== {p.dir, p.stp, p.dig}) begin
                        miscompares++;
                        $display("FAIL pulse_fields cyc=%0d got dir=%0b step=%0d digit=%0d want dir=%0b step=%0d digit=%0d",
                                 cyc, direction, step, digit_idx, p.dir, p.stp, p.dig);
                    end
                end
            end
            vectors++;
            if ({direction, step, digit_idx} !== {m_dir, step_for(m_digit), 2'(m_digit)}) begin
                miscompares++;
                $display("FAIL state cyc=%0d got dir=%0b step=%0d digit=%0d want dir=%0b step=%0d digit=%0d",
                         cyc, direction, step, digit_idx, m_dir, step_for(m_digit), m_digit);
            end
        end
    end

    task automatic drive(input logic u, input logic d, input logic s, input int n);
        btn_up  = u;
        btn_dn  = d;
        btn_sel = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge; buttons keep their level.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_out("reset_direction", int'(direction), 0);
        check_out("reset_enable",    int'(enable),    0);
        check_out("reset_step",      int'(step),      1);
        check_out("reset_digit_idx", int'(digit_idx), 0);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        btn_up  = 1'b0;
        btn_dn  = 1'b0;
        btn_sel = 1'b0;
        #1;
        do_reset();
        drive(0, 0, 0, 4);

        // Short up press, long down hold.
        drive(1, 0, 0, 5);
        drive(0, 0, 0, 10);
        drive(0, 1, 0, 40);
        drive(0, 0, 0, 10);

        // Five digit selects in idle, then a select during an up hold.
        repeat (5) begin
            drive(0, 0, 1, 2);
            drive(0, 0, 0, 3);
        end
        drive(1, 0, 0, 4);
        drive(1, 0, 1, 3);
        drive(1, 0, 0, 5);
        drive(0, 0, 0, 6);

        // Up held, down joins at E+5, down released while up stays.
        drive(1, 0, 0, 8);
        drive(1, 1, 0, 10);
        drive(1, 0, 0, 6);
        drive(0, 0, 0, 6);

        // Back to digit 0, then select and up rise together.
        repeat (3) begin
            drive(0, 0, 1, 2);
            drive(0, 0, 0, 3);
        end
        drive(1, 0, 1, 2);
        drive(1, 0, 0, 4);
        drive(0, 0, 0, 6);

        // Reset in the middle of a down hold while the button stays pressed.
        drive(0, 1, 0, 20);
        do_reset();
        drive(0, 1, 0, 20);
        drive(0, 0, 0, 8);

        // Random button activity.
        repeat (80) begin
            drive(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 4) == 0),
                  int'($urandom_range(1, 30)));
        end

        drive(0, 0, 0, 20);
        check_out("pending_pulses", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- User-input sequencer for the 4-digit decimal step counter (range 0-9999, step 1/10/100/1000).
- Converts pushbutton levels (up, down, digit-select) into the counter's direction, single-cycle enable pulses and step magnitude.
- Provides hold-to-repeat behaviour.
- Sits between the board button conditioning logic and the counter. The digit index also drives display digit highlighting.

Parameters:
- TICK_DIV, 50000: clk cycles per timing tick (1 kHz at 50 MHz).
- HOLD_DELAY, 500: ticks from the first pulse to the first auto-repeat pulse.
- REPEAT_PERIOD, 100: ticks between auto-repeat pulses.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- btn_up  input  1  increment button, active-high, debounced, asynchronous to clk.
- btn_dn  input  1  decrement button, active-high, debounced, asynchronous to clk.
- btn_sel  input  1  digit-select button, active-high, debounced, asynchronous to clk.
- direction  output  1  1 = count up, 0 = count down; registered.
- enable  output  1  one-clk pulse per counter step; registered.
- step  output  10  step magnitude: 1, 10, 100 or 1000; registered.
- digit_idx  output  2  active digit: 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands.

Behaviour:
- Reset, asynchronous while reset_n low:
  - direction = 0, enable = 0, digit_idx = 0, step = 1.
  - FSM = IDLE; prescaler and tick counter = 0; synchronizer flops = 0; sel edge-detect flop = 0.
- Input synchronization:
  - Each button passes through a 2-flop synchronizer; outputs are up_s, dn_s, sel_s.
  - sel edge = sel_s high AND previous sel_s low.
- Step mapping is registered together with digit_idx: 0→1, 1→10, 2→100, 3→1000.
- FSM states: IDLE, HOLD, REPEAT.
- IDLE:
  - sel edge: digit_idx increments modulo 4 (3→0 wrap); step updates on the same edge; no pulse that cycle.
  - else if exactly one of up_s/dn_s is high:
    - direction = up_s, enable = 1 for one cycle.
    - Prescaler and tick counter cleared; go to HOLD.
  - Both high or both low: stay in IDLE, no pulse.
- HOLD:
  - Held button released, or the other button also pressed: go to IDLE, no pulse; prescaler cleared.
  - Otherwise count ticks. Prescaler counts 0..TICK_DIV-1; a tick fires when it wraps.
  - On the HOLD_DELAY-th tick: enable pulse with unchanged direction, counters cleared, go to REPEAT.
- REPEAT:
  - Same release/both-pressed exit rule as HOLD.
  - Pulse on every REPEAT_PERIOD-th tick; counters cleared after each pulse.
- Timing:
  - Raw press is sampled at edge n; enable is high in the cycle following edge n+2 (3-edge latency).
  - Pulses at cycles E, E+HOLD_DELAY*TICK_DIV, then every REPEAT_PERIOD*TICK_DIV.
- enable is never high for two consecutive cycles.
- direction changes only in a cycle where enable is asserted and is held between pulses.
- sel edges outside IDLE are ignored and not queued. step is stable for the whole press.
- Simultaneous sel edge and press in IDLE: sel has priority. The press is accepted on the following cycle, so the first pulse uses the new step.
- Saturation is handled entirely by the counter. This block keeps pulsing while a button is held.
- reset_n asserted mid-hold: immediate return to reset values; no pulse after reset release until a button is sampled high again in IDLE.
- Counter widths are sized with $clog2 of their parameter. Tick counter comparisons are made against the parameter minus 1.

Test Plan (TICK_DIV=4, HOLD_DELAY=3, REPEAT_PERIOD=2):
- Reset: hold reset_n low mid-run → direction=0, enable=0, step=1, digit_idx=0 asynchronously; no enable until a new press after release.
- Short up press lasting 5 cycles → exactly one enable pulse 3 edges after press, direction=1, step=1; FSM back to IDLE.
- Hold dn for 40 cycles → pulses at E, E+12, E+20, E+28, E+36 with direction=0; release → no further pulses.
- Press sel 5 times in IDLE → step goes 10, 100, 1000, 1, 10 and digit_idx goes 1, 2, 3, 0, 1. A sel press during an up hold → step unchanged.
- up held, then dn asserted at E+5 → no pulse at E+12, FSM returns to IDLE; releasing dn while up is still held → new first pulse with direction=1.
- sel and up rise in the same cycle from step=1 → step=10 first; enable arrives one cycle later with step=10.
